ds_fwd_issue_buffer: RTL and testbench
======================================

Name: ds_fwd_issue_buffer

Overview:
- Parametrised successor of the single-entry decode latch: a DEPTH-entry {inst,pc} queue between IF and ID/issue.
- Performs RAW checks and operand forwarding against N_FWD younger pipeline stages, stalls on not-yet-available results (load, multi-cycle mul/div), and flushes on branch redirect.
- The downstream decoder consumes the head entry and the resolved operand values.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2
N_FWD, 3, number of forwarding sources; index 0 is youngest (EX), then MEM, WB
INST_W, 32, instruction width
PC_W, 32, PC width
DATA_W, 32, register data width

Ports:
clk  in  1  clock
resetn  in  1  synchronous reset, active low
in_valid  in  1  fetch entry valid
in_allowin  out  1  queue can accept this cycle
in_bus  in  INST_W+PC_W  {inst,pc}
out_valid  out  1  head entry issued this cycle
out_allowin  in  1  execute stage accepts
out_inst  out  INST_W  head instruction
out_pc  out  PC_W  head PC
head_uses_rj  in  1  decoder: head reads rj (inst[9:5])
head_uses_r2  in  1  decoder: head reads second source
head_r2_is_rd  in  1  decoder: second source is rd (inst[4:0]), else rk (inst[14:10])
rf_raddr1  out  5  regfile read address 1 (rj)
rf_raddr2  out  5  regfile read address 2
rf_rdata1  in  DATA_W  regfile data 1
rf_rdata2  in  DATA_W  regfile data 2
fwd_dest  in  N_FWD*5  per-stage destination register; 0 = none
fwd_value  in  N_FWD*DATA_W  per-stage result
fwd_ready  in  N_FWD  per-stage result available this cycle
src1_value  out  DATA_W  resolved operand 1
src2_value  out  DATA_W  resolved operand 2
flush  in  1  branch/exception redirect
stall_cnt  out  32  hazard-stall cycle counter

Behaviour:
- Reset (resetn==0 at posedge clk): queue empty, rd_ptr=wr_ptr=0, count=0, stall_cnt=0.
  - Consequences: out_valid=0, in_allowin=1.
- Queue state:
  - Circular buffer; pointers have clog2(DEPTH) bits and wrap modulo DEPTH.
  - count has clog2(DEPTH)+1 bits.
- in_allowin = (count != DEPTH). It does not depend on out_allowin, so there is no combinational path; when full, a push is refused even if a pop occurs in the same cycle.
- Push: in_valid && in_allowin && !flush.
- Pop: out_valid && out_allowin.
- Push and pop in the same cycle leave count unchanged.
- Zero bypass: a pushed entry becomes the head at the earliest in the next cycle. Minimum latency from in to out is 1 cycle.
- Head addresses:
  - rf_raddr1 = head inst[9:5].
  - rf_raddr2 = head_r2_is_rd ? inst[4:0] : inst[14:10].
  - Both are driven from the head even when the queue is empty.
- Forward resolution, per operand with address a:
  - If a==0 or the operand is unused: value = rf_rdata, no hazard.
  - Otherwise scan stages 0..N_FWD-1. The lowest index with fwd_dest==a wins.
  - Winner with fwd_ready=1: value = that fwd_value.
  - Winner with fwd_ready=0: hazard.
  - No match: value = rf_rdata.
- ready_go = !(hazard1 || hazard2).
- out_valid = (count!=0) && ready_go && !flush.
- stall_cnt increments (wrapping at 2^32) on each cycle with count!=0, !ready_go and !flush.
- flush:
  - Next cycle count=0 and rd_ptr=wr_ptr.
  - Push and pop are both suppressed in the flush cycle.
  - stall_cnt is preserved.
- Reset mid-stall or mid-flush: reset takes priority over everything; the queue is emptied.
- out_inst, out_pc and the src values are combinational from the head and inputs. They are don't-care when out_valid=0.

Decomposition:
- Shared package holds:
  - field positions RJ_LSB=5, RK_LSB=10, RD_LSB=0;
  - REG_ZERO=5'd0;
  - the FWD_EX=0, FWD_MEM=1, FWD_WB=2 index constants;
  - the fs_to_ds bus width INST_W+PC_W.
- One sub-module is natural: ds_fwd_mux, a combinational priority resolver (address, use flag, flattened fwd vectors, rf data → value, hazard). It is instantiated twice.

Test Plan:
1. Stream in_valid=1 with 6 entries, out_allowin=1, no hazards → each entry appears at out one cycle after push, in order; count never exceeds 1.
2. out_allowin=0 with 5 pushes at DEPTH=4 → in_allowin drops after the 4th push; the 5th is held upstream; releasing out_allowin drains pc order 0,4,8,C, then accepts the 5th.
3. Head rj=5, stage0 dest=5 ready=0, stage1 dest=5 value=0x11 ready=1 → out_valid=0 and stall_cnt increments. The next cycle stage0 ready=1 value=0x22 → out_valid=1, src1=0x22 (youngest wins, not 0x11).
4. Head rk=0, stage0 dest=0 value=0xFF → no stall, src2=rf_rdata2 (r0 never forwarded).
5. Queue holds 3 entries, flush=1 with in_valid=1 in the same cycle → next cycle count=0, out_valid=0, the flushed-cycle entry is not stored, and stall_cnt is unchanged.
6. Assert resetn=0 during a hazard stall with count=2 → next cycle count=0, stall_cnt=0, in_allowin=1.

Source files
------------

// File: rtl/ds_fwd_issue_buffer_pkg.sv
// Shared constants for the decode issue buffer: instruction field positions,
// forwarding-stage indices and fetch-to-decode bus sizing.
package ds_fwd_issue_buffer_pkg;

  typedef logic [4:0] reg_addr_t;

  localparam int RJ_LSB = 5;
  localparam int RK_LSB = 10;
  localparam int RD_LSB = 0;

  localparam reg_addr_t REG_ZERO = 5'd0;

  localparam int FWD_EX  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  localparam int INST_W_DEF     = 32;
  localparam int PC_W_DEF       = 32;
  localparam int FS_TO_DS_BUS_W = INST_W_DEF + PC_W_DEF;

  function automatic int fs_to_ds_w(input int inst_w, input int pc_w);
    return inst_w + pc_w;
  endfunction

endpackage

// File: rtl/ds_fwd_issue_buffer_if.sv
// Fetch/issue/forwarding bundle between the environment (master) and the
// issue buffer (slave).
interface ds_fwd_issue_buffer_if #(
  parameter int N_FWD  = 3,
  parameter int INST_W = 32,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic                     in_valid;
  logic                     in_allowin;
  logic [INST_W+PC_W-1:0]   in_bus;
  logic                     out_valid;
  logic                     out_allowin;
  logic [INST_W-1:0]        out_inst;
  logic [PC_W-1:0]          out_pc;
  logic                     head_uses_rj;
  logic                     head_uses_r2;
  logic                     head_r2_is_rd;
  logic [4:0]               rf_raddr1;
  logic [4:0]               rf_raddr2;
  logic [DATA_W-1:0]        rf_rdata1;
  logic [DATA_W-1:0]        rf_rdata2;
  logic [N_FWD*5-1:0]       fwd_dest;
  logic [N_FWD*DATA_W-1:0]  fwd_value;
  logic [N_FWD-1:0]         fwd_ready;
  logic [DATA_W-1:0]        src1_value;
  logic [DATA_W-1:0]        src2_value;
  logic                     flush;

  modport master (
    output in_valid, in_bus, out_allowin, head_uses_rj, head_uses_r2,
           head_r2_is_rd, rf_rdata1, rf_rdata2, fwd_dest, fwd_value,
           fwd_ready, flush,
    input  in_allowin, out_valid, out_inst, out_pc, rf_raddr1, rf_raddr2,
           src1_value, src2_value
  );

  modport slave (
    input  in_valid, in_bus, out_allowin, head_uses_rj, head_uses_r2,
           head_r2_is_rd, rf_rdata1, rf_rdata2, fwd_dest, fwd_value,
           fwd_ready, flush,
    output in_allowin, out_valid, out_inst, out_pc, rf_raddr1, rf_raddr2,
           src1_value, src2_value
  );
endinterface

// File: rtl/ds_fwd_issue_buffer_fwd_mux.sv
// Per-operand forwarding resolver: youngest matching stage wins; a match whose
// result is not ready yet reports a hazard instead of a value.
module ds_fwd_mux
  import ds_fwd_issue_buffer_pkg::*;
#(
  parameter int N_FWD  = 3,
  parameter int DATA_W = 32
) (
  input  reg_addr_t               i_addr,
  input  logic                    i_use,
  input  logic [N_FWD*5-1:0]      i_fwd_dest,
  input  logic [N_FWD*DATA_W-1:0] i_fwd_value,
  input  logic [N_FWD-1:0]        i_fwd_ready,
  input  logic [DATA_W-1:0]       i_rf_rdata,
  output logic [DATA_W-1:0]       o_value,
  output logic                    o_hazard
);

  always_comb begin
    o_value  = i_rf_rdata;
    o_hazard = 1'b0;
    if (i_use && (i_addr != REG_ZERO)) begin
      // Walk oldest to youngest so the lowest matching index is the last write.
      for (int i = N_FWD - 1; i >= 0; i--) begin
        if (i_fwd_dest[i*5 +: 5] == i_addr) begin
          o_value  = i_fwd_ready[i] ? i_fwd_value[i*DATA_W +: DATA_W] : i_rf_rdata;
          o_hazard = !i_fwd_ready[i];
        end
      end
    end
  end

endmodule

// File: rtl/ds_fwd_issue_buffer.sv
// DEPTH-entry {inst,pc} queue between fetch and issue with RAW hazard
// detection, operand forwarding, redirect flush and a stall-cycle counter.
module ds_fwd_issue_buffer
  import ds_fwd_issue_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int N_FWD  = 3,
  parameter int INST_W = INST_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  ds_fwd_issue_buffer_if.slave  io_ds,
  output logic [31:0]           o_stall_cnt
);

  localparam int BUS_W = fs_to_ds_w(INST_W, PC_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [BUS_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_stall_cnt;

  logic [BUS_W-1:0]  w_head;
  logic [INST_W-1:0] w_head_inst;
  reg_addr_t         w_raddr1;
  reg_addr_t         w_raddr2;
  logic              w_hazard1;
  logic              w_hazard2;
  logic              w_ready_go;
  logic              w_not_empty;
  logic              w_push;
  logic              w_pop;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_inst = w_head[BUS_W-1 -: INST_W];
  assign w_raddr1    = w_head_inst[RJ_LSB +: 5];
  assign w_raddr2    = io_ds.head_r2_is_rd ? w_head_inst[RD_LSB +: 5]
                                           : w_head_inst[RK_LSB +: 5];

  ds_fwd_mux #(.N_FWD(N_FWD), .DATA_W(DATA_W)) u_fwd1 (
    .i_addr      (w_raddr1),
    .i_use       (io_ds.head_uses_rj),
    .i_fwd_dest  (io_ds.fwd_dest),
    .i_fwd_value (io_ds.fwd_value),
    .i_fwd_ready (io_ds.fwd_ready),
    .i_rf_rdata  (io_ds.rf_rdata1),
    .o_value     (io_ds.src1_value),
    .o_hazard    (w_hazard1)
  );

  ds_fwd_mux #(.N_FWD(N_FWD), .DATA_W(DATA_W)) u_fwd2 (
    .i_addr      (w_raddr2),
    .i_use       (io_ds.head_uses_r2),
    .i_fwd_dest  (io_ds.fwd_dest),
    .i_fwd_value (io_ds.fwd_value),
    .i_fwd_ready (io_ds.fwd_ready),
    .i_rf_rdata  (io_ds.rf_rdata2),
    .o_value     (io_ds.src2_value),
    .o_hazard    (w_hazard2)
  );

  assign w_ready_go  = !(w_hazard1 || w_hazard2);
  assign w_not_empty = (r_count != '0);

  // Full is judged on the registered count only, so a same-cycle pop never
  // opens the input and there is no out_allowin -> in_allowin path.
  assign io_ds.in_allowin = (r_count != CNT_FULL);
  assign io_ds.out_valid  = w_not_empty && w_ready_go && !io_ds.flush;
  assign io_ds.out_inst   = w_head_inst;
  assign io_ds.out_pc     = w_head[PC_W-1:0];
  assign io_ds.rf_raddr1  = w_raddr1;
  assign io_ds.rf_raddr2  = w_raddr2;

  assign w_push = io_ds.in_valid && io_ds.in_allowin && !io_ds.flush;
  assign w_pop  = io_ds.out_valid && io_ds.out_allowin;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= io_ds.in_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (io_ds.flush) begin
        r_rd_ptr <= r_wr_ptr;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
      if (w_not_empty && !w_ready_go && !io_ds.flush) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ds_fwd_issue_buffer.sv
// Directed bench for the issue buffer: stimulus queues expected issues, a
// negedge monitor compares every accepted head against that queue.
module tb_ds_fwd_issue_buffer;
  import ds_fwd_issue_buffer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int N_FWD  = 3;
  localparam int INST_W = 32;
  localparam int PC_W   = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic [31:0] stall_cnt;
  int          total;
  int          bad;
  exp_t        sb[$];
  exp_t        mon_e;

  ds_fwd_issue_buffer_if #(.N_FWD(N_FWD), .INST_W(INST_W), .PC_W(PC_W), .DATA_W(DATA_W)) ifc ();

  ds_fwd_issue_buffer #(
    .DEPTH(DEPTH), .N_FWD(N_FWD), .INST_W(INST_W), .PC_W(PC_W), .DATA_W(DATA_W)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .io_ds       (ifc.slave),
    .o_stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rf_fn(input logic [4:0] a);
    return {24'hA5A5A0, 3'b000, a};
  endfunction

  function automatic logic [31:0] mk_inst(input logic [4:0] rd, input logic [4:0] rj,
                                          input logic [4:0] rk);
    return {17'h0, rk, rj, rd};
  endfunction

  // Register file model
  always_comb begin
    ifc.rf_rdata1 = rf_fn(ifc.rf_raddr1);
    ifc.rf_rdata2 = rf_fn(ifc.rf_raddr2);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fwd(input int stage, input logic [4:0] dest, input logic [31:0] value,
                         input logic ready);
    ifc.fwd_dest[stage*5 +: 5]           = dest;
    ifc.fwd_value[stage*DATA_W +: DATA_W] = value;
    ifc.fwd_ready[stage]                  = ready;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
    ifc.in_valid = 1'b1;
    ifc.in_bus   = {inst, pc};
  endtask

  task automatic expect_issue(input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] s1, input logic [31:0] s2);
    exp_t e;
    e.pc = pc; e.inst = inst; e.s1 = s1; e.s2 = s2;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (resetn && ifc.out_valid && ifc.out_allowin) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_issue got_pc=%h exp=none", ifc.out_pc);
      end else begin
        mon_e = sb.pop_front();
        check("issue_pc",   ifc.out_pc,     mon_e.pc);
        check("issue_inst", ifc.out_inst,   mon_e.inst);
        check("issue_src1", ifc.src1_value, mon_e.s1);
        check("issue_src2", ifc.src2_value, mon_e.s2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] inst;
    total = 0;
    bad   = 0;
    resetn            = 1'b0;
    ifc.in_valid      = 1'b0;
    ifc.in_bus        = '0;
    ifc.out_allowin   = 1'b1;
    ifc.head_uses_rj  = 1'b1;
    ifc.head_uses_r2  = 1'b1;
    ifc.head_r2_is_rd = 1'b0;
    ifc.fwd_dest      = '0;
    ifc.fwd_value     = '0;
    ifc.fwd_ready     = '0;
    ifc.flush         = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    check("rst_out_valid",  {31'b0, ifc.out_valid},  32'd0);
    check("rst_in_allowin", {31'b0, ifc.in_allowin}, 32'd1);
    check("rst_stall_cnt",  stall_cnt,               32'd0);

    // 1: streaming, one-cycle latency, head always the latest push
    for (int k = 0; k < 6; k++) begin
      inst = mk_inst(5'(k + 3), 5'(k + 1), 5'(k + 2));
      drive(32'h100 + 32'(4 * k), inst);
      expect_issue(32'h100 + 32'(4 * k), inst, rf_fn(5'(k + 1)), rf_fn(5'(k + 2)));
      tick();
      check("stream_valid", {31'b0, ifc.out_valid}, 32'd1);
      check("stream_head",  ifc.out_pc, 32'h100 + 32'(4 * k));
    end
    ifc.in_valid = 1'b0;
    tick();
    check("stream_drained", {31'b0, ifc.out_valid}, 32'd0);

    // 2: fill to DEPTH, hold fifth upstream, then drain in order
    ifc.out_allowin = 1'b0;
    for (int k = 0; k < 5; k++) begin
      inst = mk_inst(5'(k + 10), 5'(k + 1), 5'(k + 2));
      expect_issue(32'(4 * k), inst, rf_fn(5'(k + 1)), rf_fn(5'(k + 2)));
    end
    for (int k = 0; k < 4; k++) begin
      drive(32'(4 * k), mk_inst(5'(k + 10), 5'(k + 1), 5'(k + 2)));
      tick();
    end
    check("full_allowin", {31'b0, ifc.in_allowin}, 32'd0);
    drive(32'h10, mk_inst(5'd14, 5'd5, 5'd6));
    tick();
    check("full_held_allowin", {31'b0, ifc.in_allowin}, 32'd0);
    check("full_head_pc",      ifc.out_pc, 32'h0);
    ifc.out_allowin = 1'b1;
    tick();
    check("full_reopen", {31'b0, ifc.in_allowin}, 32'd1);
    check("full_head2",  ifc.out_pc, 32'h4);
    tick();
    ifc.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("full_drained", {31'b0, ifc.out_valid}, 32'd0);

    // 3: load-use stall, youngest stage wins once ready
    set_fwd(FWD_EX,  5'd5, 32'h99, 1'b0);
    set_fwd(FWD_MEM, 5'd5, 32'h11, 1'b1);
    inst = mk_inst(5'd7, 5'd5, 5'd6);
    drive(32'h200, inst);
    expect_issue(32'h200, inst, 32'h22, rf_fn(5'd6));
    tick();
    ifc.in_valid = 1'b0;
    #1;
    check("haz_valid0", {31'b0, ifc.out_valid}, 32'd0);
    check("haz_stall0", stall_cnt, 32'd0);
    tick();
    check("haz_stall1", stall_cnt, 32'd1);
    check("haz_valid1", {31'b0, ifc.out_valid}, 32'd0);
    set_fwd(FWD_EX, 5'd5, 32'h22, 1'b1);
    #1;
    check("haz_release", {31'b0, ifc.out_valid}, 32'd1);
    tick();
    check("haz_stall_hold", stall_cnt, 32'd1);
    check("haz_empty", {31'b0, ifc.out_valid}, 32'd0);
    ifc.fwd_dest = '0; ifc.fwd_value = '0; ifc.fwd_ready = '0;

    // 4: r0 never forwarded; then rd as second source with MEM/WB forwarding
    set_fwd(FWD_EX, 5'd0, 32'hFF, 1'b1);
    inst = mk_inst(5'd4, 5'd3, 5'd0);
    drive(32'h240, inst);
    expect_issue(32'h240, inst, rf_fn(5'd3), rf_fn(5'd0));
    tick();
    ifc.in_valid = 1'b0;
    #1;
    check("r0_valid", {31'b0, ifc.out_valid}, 32'd1);
    tick();
    ifc.head_r2_is_rd = 1'b1;
    set_fwd(FWD_MEM, 5'd8, 32'h44, 1'b1);
    set_fwd(FWD_WB,  5'd9, 32'h33, 1'b1);
    inst = mk_inst(5'd9, 5'd8, 5'd0);
    drive(32'h244, inst);
    expect_issue(32'h244, inst, 32'h44, 32'h33);
    tick();
    ifc.in_valid = 1'b0;
    #1;
    check("rd_valid", {31'b0, ifc.out_valid}, 32'd1);
    check("rd_raddr2", {27'b0, ifc.rf_raddr2}, 32'd9);
    tick();
    ifc.head_r2_is_rd = 1'b0;
    ifc.fwd_dest = '0; ifc.fwd_value = '0; ifc.fwd_ready = '0;
    check("fwd_stall_same", stall_cnt, 32'd1);

    // 5: flush with three queued entries and a concurrent push
    ifc.out_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(32'h300 + 32'(4 * k), mk_inst(5'd1, 5'd2, 5'd3));
      tick();
    end
    ifc.flush = 1'b1;
    drive(32'h30C, mk_inst(5'd1, 5'd2, 5'd3));
    #1;
    check("flush_valid_now", {31'b0, ifc.out_valid}, 32'd0);
    tick();
    ifc.flush    = 1'b0;
    ifc.in_valid = 1'b0;
    #1;
    check("flush_empty", {31'b0, ifc.out_valid}, 32'd0);
    check("flush_allowin", {31'b0, ifc.in_allowin}, 32'd1);
    check("flush_stall", stall_cnt, 32'd1);
    ifc.out_allowin = 1'b1;
    inst = mk_inst(5'd11, 5'd12, 5'd13);
    drive(32'h310, inst);
    expect_issue(32'h310, inst, rf_fn(5'd12), rf_fn(5'd13));
    tick();
    ifc.in_valid = 1'b0;
    #1;
    check("flush_after_valid", {31'b0, ifc.out_valid}, 32'd1);
    check("flush_after_pc", ifc.out_pc, 32'h310);
    tick();

    // 6: reset in the middle of a stall with two entries queued
    set_fwd(FWD_EX, 5'd5, 32'h0, 1'b0);
    drive(32'h400, mk_inst(5'd1, 5'd5, 5'd2));
    tick();
    drive(32'h404, mk_inst(5'd1, 5'd5, 5'd2));
    tick();
    ifc.in_valid = 1'b0;
    #1;
    check("rst2_stall_pre", stall_cnt, 32'd2);
    check("rst2_valid_pre", {31'b0, ifc.out_valid}, 32'd0);
    resetn = 1'b0;
    tick();
    check("rst2_stall", stall_cnt, 32'd0);
    check("rst2_allowin", {31'b0, ifc.in_allowin}, 32'd1);
    resetn = 1'b1;
    ifc.fwd_dest = '0; ifc.fwd_value = '0; ifc.fwd_ready = '0;
    #1;
    check("rst2_empty", {31'b0, ifc.out_valid}, 32'd0);
    tick();
    check("rst2_still_empty", {31'b0, ifc.out_valid}, 32'd0);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
